// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and helpers for the direct-mapped
// write-through data cache controller.
package dcache_pkg;

   localparam int WORD_SIZE  = 16;
   localparam int LINE_WORDS = 4;
   localparam int LINES      = 8;
   localparam int INDEX_W    = 3;
   localparam int TAG_W      = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hffff) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data storage for the data cache: combinational lookup port and a
// single write port doing either a full-line fill or a one-word update.
module dcache_line_store #(
   parameter int LINES      = 8,
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = $clog2(LINES),
   parameter int OFF_W      = $clog2(LINE_WORDS),
   parameter int TAG_B      = WORD_SIZE - IDX_W - OFF_W
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [IDX_W-1:0]                rd_index,
   input  logic [TAG_B-1:0]                rd_tag,
   input  logic [OFF_W-1:0]                rd_offset,
   output logic                            hit,
   output logic [WORD_SIZE-1:0]            rd_word,
   input  logic                            wr_en,
   input  logic                            wr_fill,
   input  logic [IDX_W-1:0]                wr_index,
   input  logic [TAG_B-1:0]                wr_tag,
   input  logic [OFF_W-1:0]                wr_offset,
   input  logic [WORD_SIZE-1:0]            wr_word,
   input  logic [LINE_WORDS*WORD_SIZE-1:0] wr_line
);

   logic [LINES-1:0]     valid_r;
   logic [TAG_B-1:0]     tag_r  [LINES];
   logic [WORD_SIZE-1:0] data_r [LINES][LINE_WORDS];

   // Lookup: hit when the indexed line is valid and its tag matches.
   always_comb begin
      hit     = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
      rd_word = data_r[rd_index][rd_offset];
   end

   // Storage update; reset only needs to drop the valid bits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_r <= '0;
      end else if (wr_en) begin
         if (wr_fill) begin
            valid_r[wr_index] <= 1'b1;
            tag_r[wr_index]   <= wr_tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
               data_r[wr_index][k] <= wr_line[k*WORD_SIZE +: WORD_SIZE];
            end
         end else begin
            data_r[wr_index][wr_offset] <= wr_word;
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// between the CPU data port and a line-fill memory interface.
module dcache_ctrl #(
   parameter int WORD_SIZE  = dcache_pkg::WORD_SIZE,
   parameter int LINES      = dcache_pkg::LINES,
   parameter int LINE_WORDS = dcache_pkg::LINE_WORDS
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cpu_read,
   input  logic                          cpu_write,
   input  logic [WORD_SIZE-1:0]          cpu_address,
   input  logic [WORD_SIZE-1:0]          cpu_wdata,
   output logic [WORD_SIZE-1:0]          cpu_rdata,
   output logic                          cpu_ready,
   output logic                          d_readM,
   output logic                          d_writeM,
   output logic [WORD_SIZE-1:0]          d_address,
   inout  wire  [LINE_WORDS*WORD_SIZE:0] d_data,
   output logic [15:0]                   hit_count,
   output logic [15:0]                   miss_count
);
   import dcache_pkg::*;

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_B  = WORD_SIZE - IDX_W - OFF_W;
   localparam int LINE_B = LINE_WORDS * WORD_SIZE;

   state_t               state_r;
   logic [WORD_SIZE-1:0] addr_r;
   logic [WORD_SIZE-1:0] wdata_r;
   logic                 drive_r;

   logic [WORD_SIZE-1:0] lookup_addr_s;
   logic                 hit_s;
   logic [WORD_SIZE-1:0] hit_word_s;
   logic                 fill_done_s;
   logic                 wr_en_s;
   logic                 wr_fill_s;
   logic [WORD_SIZE-1:0] fill_word_s;

   // Lookup uses the live CPU address while idle, the latched one afterwards.
   always_comb begin
      if (state_r == IDLE) begin
         lookup_addr_s = cpu_address;
      end else begin
         lookup_addr_s = addr_r;
      end
      fill_done_s = (state_r == FILL) && (d_data[LINE_B] == 1'b1);
      wr_fill_s   = (state_r == FILL);
      wr_en_s     = fill_done_s || ((state_r == WRITE) && hit_s);
      fill_word_s = d_data[int'(addr_r[OFF_W-1:0])*WORD_SIZE +: WORD_SIZE];
   end

   dcache_line_store #(
      .LINES     (LINES),
      .WORD_SIZE (WORD_SIZE),
      .LINE_WORDS(LINE_WORDS)
   ) u_line_store (
      .clk      (clk),
      .reset_n  (reset_n),
      .rd_index (lookup_addr_s[OFF_W +: IDX_W]),
      .rd_tag   (lookup_addr_s[WORD_SIZE-1 -: TAG_B]),
      .rd_offset(lookup_addr_s[OFF_W-1:0]),
      .hit      (hit_s),
      .rd_word  (hit_word_s),
      .wr_en    (wr_en_s),
      .wr_fill  (wr_fill_s),
      .wr_index (addr_r[OFF_W +: IDX_W]),
      .wr_tag   (addr_r[WORD_SIZE-1 -: TAG_B]),
      .wr_offset(addr_r[OFF_W-1:0]),
      .wr_word  (wdata_r),
      .wr_line  (d_data[LINE_B-1:0])
   );

   // Only the low word is driven during a store so memory writes a single word.
   assign d_data = drive_r ? {{(LINE_B - WORD_SIZE + 1){1'bz}}, wdata_r}
                           : {(LINE_B + 1){1'bz}};

   // Controller FSM with registered bus and CPU outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         addr_r     <= '0;
         wdata_r    <= '0;
         drive_r    <= 1'b0;
         cpu_rdata  <= '0;
         cpu_ready  <= 1'b0;
         d_readM    <= 1'b0;
         d_writeM   <= 1'b0;
         d_address  <= '0;
         hit_count  <= 16'd0;
         miss_count <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cpu_write) begin
                  addr_r    <= cpu_address;
                  wdata_r   <= cpu_wdata;
                  drive_r   <= 1'b1;
                  d_writeM  <= 1'b1;
                  d_address <= cpu_address;
                  state_r   <= WRITE;
               end else if (cpu_read) begin
                  addr_r <= cpu_address;
                  if (hit_s) begin
                     cpu_rdata <= hit_word_s;
                     cpu_ready <= 1'b1;
                     hit_count <= sat_inc(hit_count);
                     state_r   <= RESP;
                  end else begin
                     miss_count <= sat_inc(miss_count);
                     d_readM    <= 1'b1;
                     d_address  <= {cpu_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                     state_r    <= FILL;
                  end
               end
            end
            FILL: begin
               if (fill_done_s) begin
                  cpu_rdata <= fill_word_s;
                  cpu_ready <= 1'b1;
                  d_readM   <= 1'b0;
                  state_r   <= RESP;
               end
            end
            WRITE: begin
               drive_r   <= 1'b0;
               d_writeM  <= 1'b0;
               cpu_ready <= 1'b1;
               state_r   <= RESP;
            end
            RESP: begin
               cpu_ready <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               drive_r   <= 1'b0;
               d_readM   <= 1'b0;
               d_writeM  <= 1'b0;
               cpu_ready <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a cache/memory model.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_read;
   logic        cpu_write;
   logic [15:0] cpu_address;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        d_readM;
   logic        d_writeM;
   logic [15:0] d_address;
   wire  [64:0] d_data;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   dcache_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_address(cpu_address),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .d_readM    (d_readM),
      .d_writeM   (d_writeM),
      .d_address  (d_address),
      .d_data     (d_data),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Memory side of the bus
   logic [15:0] mem [65536];
   logic        mem_drive = 1'b0;
   logic        mem_hold  = 1'b0;
   logic [63:0] mem_line  = 64'd0;
   int          lat_cnt   = 0;
   int          lat_target = 0;

   assign d_data = mem_drive ? {1'b1, mem_line} : {65{1'bz}};

   always @(negedge clk) begin
      if (d_readM && !mem_hold) begin
         if (!mem_drive) begin
            if (lat_cnt == 0) lat_target = $urandom_range(0, 3);
            if (lat_cnt >= lat_target) begin
               logic [15:0] b;
               b = {d_address[15:2], 2'b00};
               mem_line  = {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
               mem_drive = 1'b1;
            end
            lat_cnt++;
         end
      end else begin
         mem_drive = 1'b0;
         lat_cnt   = 0;
      end
   end

   always @(posedge clk) begin
      if (d_writeM) mem[d_address] <= d_data[15:0];
   end

   // Reference model: memory image plus which line tags the cache holds
   logic [15:0] ref_mem [65536];
   bit          ref_valid [8];
   logic [10:0] ref_tag [8];
   int          ref_hits;
   int          ref_misses;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   task automatic do_load(input logic [15:0] addr);
      int   idx;
      bit   exp_hit;
      int   n;
      bit   saw_read;
      bit   saw_write;
      bit   addr_ok;
      idx     = int'(addr[4:2]);
      exp_hit = ref_valid[idx] && (ref_tag[idx] == addr[15:5]);
      @(negedge clk);
      check_eq("ready_pulse", cpu_ready, 1'b0);
      cpu_read    = 1'b1;
      cpu_write   = 1'b0;
      cpu_address = addr;
      n = 0; saw_read = 0; saw_write = 0; addr_ok = 1;
      while (n < 64) begin
         @(negedge clk);
         n++;
         if (cpu_ready) break;
         if (d_readM) begin
            saw_read = 1;
            if (d_address != {addr[15:2], 2'b00}) addr_ok = 0;
         end
         if (d_writeM) saw_write = 1;
      end
      check_eq("ld_ready", cpu_ready, 1'b1);
      if (exp_hit) begin
         ref_hits = (ref_hits < 65535) ? ref_hits + 1 : ref_hits;
         check_eq("hit_latency", n, 1);
         check_eq("hit_no_fill", saw_read, 1'b0);
      end else begin
         ref_misses = (ref_misses < 65535) ? ref_misses + 1 : ref_misses;
         check_eq("miss_fill", saw_read, 1'b1);
         check_eq("fill_addr", addr_ok, 1'b1);
         check_eq("readM_low_at_ready", d_readM, 1'b0);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = addr[15:5];
      end
      check_eq("ld_no_write", saw_write, 1'b0);
      check_eq("ld_data", cpu_rdata, ref_mem[addr]);
      check_eq("hit_count", hit_count, ref_hits);
      check_eq("miss_count", miss_count, ref_misses);
      cpu_read = 1'b0;
   endtask

   task automatic do_store(input logic [15:0] addr, input logic [15:0] data, input bit also_read);
      @(negedge clk);
      check_eq("ready_pulse", cpu_ready, 1'b0);
      cpu_write   = 1'b1;
      cpu_read    = also_read;
      cpu_address = addr;
      cpu_wdata   = data;
      @(negedge clk);
      check_eq("st_writeM", d_writeM, 1'b1);
      check_eq("st_no_readM", d_readM, 1'b0);
      check_eq("st_addr", d_address, addr);
      check_eq("st_data", d_data[15:0], data);
      check_eq("st_not_ready", cpu_ready, 1'b0);
      @(negedge clk);
      check_eq("st_ready", cpu_ready, 1'b1);
      check_eq("st_writeM_low", d_writeM, 1'b0);
      check_eq("st_miss_count", miss_count, ref_misses);
      check_eq("st_hit_count", hit_count, ref_hits);
      ref_mem[addr] = data;
      cpu_write = 1'b0;
      cpu_read  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h0000] = 16'h9023; ref_mem[16'h0000] = 16'h9023;
      mem[16'h0001] = 16'h0001; ref_mem[16'h0001] = 16'h0001;
      mem[16'h0002] = 16'hffff; ref_mem[16'h0002] = 16'hffff;
      mem[16'h0023] = 16'h6000; ref_mem[16'h0023] = 16'h6000;
      model_reset();

      reset_n     = 1'b0;
      cpu_read    = 1'b0;
      cpu_write   = 1'b0;
      cpu_address = 16'h0000;
      cpu_wdata   = 16'h0000;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", cpu_ready, 1'b0);
      check_eq("rst_rdata", cpu_rdata, 16'h0000);
      check_eq("rst_readM", d_readM, 1'b0);
      check_eq("rst_writeM", d_writeM, 1'b0);
      check_eq("rst_daddr", d_address, 16'h0000);
      check_eq("rst_hits", hit_count, 16'h0000);
      check_eq("rst_misses", miss_count, 16'h0000);
      reset_n = 1'b1;

      // Directed scenarios from the cold-start sequence
      do_load(16'h0001);
      do_load(16'h0002);
      do_store(16'h0001, 16'h1234, 1'b0);
      do_load(16'h0001);
      do_load(16'h0023);
      do_load(16'h0003);
      do_load(16'h0023);
      do_store(16'h0022, 16'h5a5a, 1'b1);
      do_load(16'h0022);

      // Reset while a fill is outstanding
      mem_hold = 1'b1;
      @(negedge clk);
      cpu_read    = 1'b1;
      cpu_address = 16'h0040;
      @(negedge clk);
      check_eq("midfill_readM", d_readM, 1'b1);
      reset_n  = 1'b0;
      cpu_read = 1'b0;
      @(negedge clk);
      check_eq("midfill_rst_readM", d_readM, 1'b0);
      check_eq("midfill_rst_ready", cpu_ready, 1'b0);
      check_eq("midfill_rst_misses", miss_count, 16'h0000);
      reset_n  = 1'b1;
      mem_hold = 1'b0;
      model_reset();
      do_load(16'h0000);
      check_eq("post_rst_data", cpu_rdata, 16'h9023);
      do_load(16'h0001);

      // Random mix of loads, stores and simultaneous requests
      for (int t = 0; t < 250; t++) begin
         int          r;
         logic [15:0] a;
         r = $urandom_range(0, 9);
         a = 16'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) a = 16'($urandom);
         if (r < 6)       do_load(a);
         else if (r < 9)  do_store(a, 16'($urandom), 1'b0);
         else             do_store(a, 16'($urandom), 1'b1);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
